matrix_operand_sequencer: RTL and testbench

MATRIX_OPERAND_SEQUENCER -- requirements
Module: matrix_operand_sequencer

---
 rtl/matrix_operand_sequencer_if.sv | 38 +++
 rtl/matrix_operand_sequencer.sv | 151 +++++++++++++++
 tb/tb_matrix_operand_sequencer.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_operand_sequencer_if.sv
// Handshake and data bundle between the matrix operand sequencer and its peers.
// No logic; every signal is driven by exactly one side of the link.
// The slave modport is the sequencer side, the master modport the environment side.
interface matrix_operand_sequencer_if #(
    parameter int N = 4,
    parameter int W = 32
);
    logic [N*N*W-1:0] a_i;
    logic [N*N*W-1:0] b_i;
    logic             ab_i_stb;
    logic             ab_i_ack;
    logic [N*W-1:0]   row_o;
    logic             row_o_stb;
    logic             row_o_ack;
    logic [N*W-1:0]   column_o;
    logic             column_o_stb;
    logic             column_o_ack;
    logic [W-1:0]     result_i;
    logic             result_i_stb;
    logic             result_i_ack;
    logic [N*N*W-1:0] c_o;
    logic             c_o_stb;
    logic             c_o_ack;

    modport slave (
        input  a_i, b_i, ab_i_stb, row_o_ack, column_o_ack,
        input  result_i, result_i_stb, c_o_ack,
        output ab_i_ack, row_o, row_o_stb, column_o, column_o_stb,
        output result_i_ack, c_o, c_o_stb
    );

    modport master (
        output a_i, b_i, ab_i_stb, row_o_ack, column_o_ack,
        output result_i, result_i_stb, c_o_ack,
        input  ab_i_ack, row_o, row_o_stb, column_o, column_o_stb,
        input  result_i_ack, c_o, c_o_stb
    );
endinterface

// File: rtl/matrix_operand_sequencer.sv
// Sequences row/column operand pairs of A and B to an external inner-product unit and assembles C.
// Latency: 2 cycles per element with immediate peers; C valid 2*N*N+1 cycles after the A/B transfer.
// Backpressure: every stb holds with stable data until its ack; one inner product outstanding at a time.
module matrix_operand_sequencer #(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    matrix_operand_sequencer_if.slave        sq_if,
    output logic                             busy
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int MW = N * N * W;
    localparam int VW = N * W;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES, OUTPUT} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   i_q, i_d, j_q, j_d;
    logic [MW-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
    logic            ab_ack_q, ab_ack_d;
    logic            row_stb_q, row_stb_d;
    logic            col_stb_q, col_stb_d;
    logic            res_ack_q, res_ack_d;
    logic            c_stb_q, c_stb_d;
    logic [VW-1:0]   row_dat, col_dat;
    logic            ab_xfer, row_xfer, col_xfer, res_xfer, c_xfer;

    assign ab_xfer  = sq_if.ab_i_stb && ab_ack_q;
    assign row_xfer = row_stb_q && sq_if.row_o_ack;
    assign col_xfer = col_stb_q && sq_if.column_o_ack;
    assign res_xfer = sq_if.result_i_stb && res_ack_q;
    assign c_xfer   = c_stb_q && sq_if.c_o_ack;

    // Operand selection: row i of A is contiguous, column j of B is gathered one element per row.
    always_comb begin
        row_dat = a_q[VW*(N-int'(i_q))-1 -: VW];
        col_dat = '0;
        for (int r = 0; r < N; r++) begin
            col_dat[W*(N-r)-1 -: W] = b_q[W*(N*N-N*r-int'(j_q))-1 -: W];
        end
    end

    // Next-state and registered-output computation for the sequencing FSM.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        ab_ack_d  = ab_ack_q;
        row_stb_d = row_stb_q;
        col_stb_d = col_stb_q;
        res_ack_d = res_ack_q;
        c_stb_d   = c_stb_q;
        case (state_q)
            IDLE: begin
                ab_ack_d = 1'b1;
                if (ab_xfer) begin
                    a_d       = sq_if.a_i;
                    b_d       = sq_if.b_i;
                    i_d       = '0;
                    j_d       = '0;
                    ab_ack_d  = 1'b0;
                    row_stb_d = 1'b1;
                    col_stb_d = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                // Each side drops independently; leave once neither is still pending.
                if (row_xfer) row_stb_d = 1'b0;
                if (col_xfer) col_stb_d = 1'b0;
                if ((!row_stb_q || row_xfer) && (!col_stb_q || col_xfer)) begin
                    res_ack_d = 1'b1;
                    state_d   = WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (res_xfer) begin
                    c_d[W*(N*N-N*int'(i_q)-int'(j_q))-1 -: W] = sq_if.result_i;
                    res_ack_d = 1'b0;
                    if (i_q == LAST && j_q == LAST) begin
                        c_stb_d = 1'b1;
                        state_d = OUTPUT;
                    end else begin
                        if (j_q == LAST) begin
                            j_d = '0;
                            i_d = i_q + 1'b1;
                        end else begin
                            j_d = j_q + 1'b1;
                        end
                        row_stb_d = 1'b1;
                        col_stb_d = 1'b1;
                        state_d   = ISSUE;
                    end
                end
            end
            OUTPUT: begin
                if (c_xfer) begin
                    c_stb_d  = 1'b0;
                    ab_ack_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight product.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            i_q       <= '0;
            j_q       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            ab_ack_q  <= 1'b0;
            row_stb_q <= 1'b0;
            col_stb_q <= 1'b0;
            res_ack_q <= 1'b0;
            c_stb_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            ab_ack_q  <= ab_ack_d;
            row_stb_q <= row_stb_d;
            col_stb_q <= col_stb_d;
            res_ack_q <= res_ack_d;
            c_stb_q   <= c_stb_d;
        end
    end

    assign sq_if.ab_i_ack     = ab_ack_q;
    assign sq_if.row_o        = row_dat;
    assign sq_if.row_o_stb    = row_stb_q;
    assign sq_if.column_o     = col_dat;
    assign sq_if.column_o_stb = col_stb_q;
    assign sq_if.result_i_ack = res_ack_q;
    assign sq_if.c_o          = c_q;
    assign sq_if.c_o_stb      = c_stb_q;
    assign busy               = (state_q != IDLE);
endmodule

// File: tb/tb_matrix_operand_sequencer.sv
// Bench for matrix_operand_sequencer: scoreboarded operand order, C contents, timing and reset.
// Downstream model returns a real-valued inner product one cycle after issue.
// Peers can stall issue acks and the C ack on demand.
module tb_matrix_operand_sequencer;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int MW = N * N * W;
    localparam int VW = N * W;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    matrix_operand_sequencer_if #(.N(N), .W(W)) sq_if ();

    matrix_operand_sequencer #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .sq_if (sq_if),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    logic [VW-1:0] exp_row_q[$];
    logic [VW-1:0] exp_col_q[$];
    logic [MW-1:0] exp_c_q[$];
    logic          man_issue = 1'b0;
    int            c_hold    = 0;
    int            n_issue   = 0;
    logic [VW-1:0] cap_row, cap_col;
    bit            have_row  = 0;
    bit            have_col  = 0;
    logic [MW-1:0] last_c    = '0;

    task automatic check(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], 11'({3'b000, f[30:23]} + 11'd896), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [30:0] mag;
        logic [10:0] e;
        d = $realtobits(r);
        e = d[62:52];
        if (e < 11'd897) return {d[63], 31'd0};
        mag = {8'(e - 11'd896), d[51:29]};
        if (d[28] && ((d[27:0] != 28'd0) || d[29])) mag = mag + 31'd1;
        return {d[63], mag};
    endfunction

    function automatic logic [31:0] el(input logic [MW-1:0] m, input int r, input int c);
        return m[W*(N*N-r*N-c)-1 -: W];
    endfunction

    function automatic logic [MW-1:0] setel(input logic [MW-1:0] m, input int r, input int c,
                                            input logic [31:0] v);
        m[W*(N*N-r*N-c)-1 -: W] = v;
        return m;
    endfunction

    function automatic logic [VW-1:0] row_of(input logic [MW-1:0] m, input int r);
        logic [VW-1:0] v;
        for (int c = 0; c < N; c++) v[W*(N-c)-1 -: W] = el(m, r, c);
        return v;
    endfunction

    function automatic logic [VW-1:0] col_of(input logic [MW-1:0] m, input int c);
        logic [VW-1:0] v;
        for (int r = 0; r < N; r++) v[W*(N-r)-1 -: W] = el(m, r, c);
        return v;
    endfunction

    function automatic logic [31:0] ip(input logic [VW-1:0] rv, input logic [VW-1:0] cv);
        real s;
        s = 0.0;
        for (int k = 0; k < N; k++) s = s + f2r(rv[W*(N-k)-1 -: W]) * f2r(cv[W*(N-k)-1 -: W]);
        return r2f(s);
    endfunction

    function automatic logic [MW-1:0] model_c(input logic [MW-1:0] a, input logic [MW-1:0] b);
        logic [MW-1:0] m;
        m = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                m = setel(m, r, c, ip(row_of(a, r), col_of(b, c)));
        return m;
    endfunction

    function automatic logic [MW-1:0] rndm();
        logic [MW-1:0] m;
        m = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                m = setel(m, r, c, {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)});
        return m;
    endfunction

    // Push the expected issue sequence and product, then transfer A/B. Returns 1ns after the transfer edge.
    task automatic load(input logic [MW-1:0] a, input logic [MW-1:0] b, input logic [MW-1:0] expc);
        int g;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                exp_row_q.push_back(row_of(a, r));
                exp_col_q.push_back(col_of(b, c));
            end
        exp_c_q.push_back(expc);
        @(negedge clk);
        sq_if.a_i      = a;
        sq_if.b_i      = b;
        sq_if.ab_i_stb = 1'b1;
        g = 0;
        while (!sq_if.ab_i_ack && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("ab_ack_wait", sq_if.ab_i_ack, 1'b1);
        @(posedge clk);
        #1;
        sq_if.ab_i_stb = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int g;
        g = 0;
        while ((exp_c_q.size() != 0 || !sq_if.ab_i_ack) && g < 400) begin
            @(posedge clk);
            #1;
            g++;
        end
        check(tag, g < 400, 1'b1);
    endtask

    // Downstream peers: inner-product unit and C consumer, acting mid-cycle.
    initial begin
        sq_if.row_o_ack    = 1'b0;
        sq_if.column_o_ack = 1'b0;
        sq_if.result_i     = '0;
        sq_if.result_i_stb = 1'b0;
        sq_if.c_o_ack      = 1'b0;
        forever begin
            @(negedge clk);
            if (!man_issue) begin
                sq_if.row_o_ack    = 1'b1;
                sq_if.column_o_ack = 1'b1;
            end
            if (sq_if.row_o_stb && sq_if.row_o_ack) begin
                cap_row  = sq_if.row_o;
                have_row = 1;
                n_issue++;
                if (exp_row_q.size() > 0) check("row_o", sq_if.row_o, exp_row_q.pop_front());
                else check("row_unexpected", 1'b1, 1'b0);
            end
            if (sq_if.column_o_stb && sq_if.column_o_ack) begin
                cap_col  = sq_if.column_o;
                have_col = 1;
                if (exp_col_q.size() > 0) check("column_o", sq_if.column_o, exp_col_q.pop_front());
                else check("col_unexpected", 1'b1, 1'b0);
            end
            if (sq_if.result_i_stb) begin
                sq_if.result_i_stb = 1'b0;
            end else if (sq_if.result_i_ack && have_row && have_col) begin
                sq_if.result_i     = ip(cap_row, cap_col);
                sq_if.result_i_stb = 1'b1;
                have_row = 0;
                have_col = 0;
            end
            if (sq_if.c_o_stb) begin
                if (c_hold > 0) begin
                    sq_if.c_o_ack = 1'b0;
                    c_hold--;
                end else begin
                    sq_if.c_o_ack = 1'b1;
                    last_c = sq_if.c_o;
                    if (exp_c_q.size() > 0) check("c_o", sq_if.c_o, exp_c_q.pop_front());
                    else check("c_unexpected", 1'b1, 1'b0);
                end
            end else begin
                sq_if.c_o_ack = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [MW-1:0] a, b, cref;
        logic [VW-1:0] r0, c0;
        int cnt, base, m, g;
        real v, dv;

        rst = 1'b1;
        sq_if.a_i = '0;
        sq_if.b_i = '0;
        sq_if.ab_i_stb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ab_ack", sq_if.ab_i_ack, 1'b0);
        check("rst_row_stb", sq_if.row_o_stb, 1'b0);
        check("rst_col_stb", sq_if.column_o_stb, 1'b0);
        check("rst_res_ack", sq_if.result_i_ack, 1'b0);
        check("rst_c_stb", sq_if.c_o_stb, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_c_o", sq_if.c_o, '0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ab_ack_after_rst", sq_if.ab_i_ack, 1'b1);

        // Identity A times B = 1..16: bit-exact B back, ordered issue, 33-cycle latency.
        a = '0;
        b = '0;
        for (int r = 0; r < N; r++) begin
            a = setel(a, r, r, 32'h3F800000);
            for (int c = 0; c < N; c++) b = setel(b, r, c, r2f(real'(r * N + c + 1)));
        end
        base = n_issue;
        load(a, b, b);
        check("busy_after_load", busy, 1'b1);
        check("issue0_row", sq_if.row_o, row_of(a, 0));
        cnt = 1;
        while (!sq_if.c_o_stb && cnt < 200) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("c_stb_latency", cnt, 33);
        wait_done("identity_done");
        check("identity_issue_count", n_issue - base, 16);

        // Datapath values with staggered first-element acks and C back-pressure.
        a = rndm();
        b = rndm();
        a = setel(a, 0, 0, r2f(10.75));
        a = setel(a, 0, 1, r2f(5.89));
        a = setel(a, 0, 2, r2f(6.48));
        a = setel(a, 0, 3, r2f(4.98));
        b = setel(b, 0, 0, r2f(1.37));
        b = setel(b, 1, 0, r2f(2.0));
        b = setel(b, 2, 0, r2f(15.3548));
        b = setel(b, 3, 0, r2f(7.0));
        man_issue = 1'b1;
        c_hold = 10;
        load(a, b, model_c(a, b));
        sq_if.row_o_ack    = 1'b0;
        sq_if.column_o_ack = 1'b1;
        r0 = sq_if.row_o;
        c0 = sq_if.column_o;
        check("first_row_msw", r0[VW-1 -: W], 32'h412C0000);
        check("stag_row_stb_c1", sq_if.row_o_stb, 1'b1);
        check("stag_col_stb_c1", sq_if.column_o_stb, 1'b1);
        for (int cyc = 2; cyc <= 5; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 2) sq_if.column_o_ack = 1'b0;
            if (cyc == 4) sq_if.row_o_ack = 1'b1;
            if (cyc == 5) begin
                sq_if.row_o_ack = 1'b0;
                man_issue = 1'b0;
            end
            check("stag_col_stb", sq_if.column_o_stb, 1'b0);
            check("stag_row_stb", sq_if.row_o_stb, cyc < 5);
            check("stag_res_ack", sq_if.result_i_ack, cyc == 5);
            check("stag_row_data", sq_if.row_o, r0);
            check("stag_col_data", sq_if.column_o, c0);
        end
        g = 0;
        while (!sq_if.c_o_stb && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("bp_c_stb_seen", sq_if.c_o_stb, 1'b1);
        cref = sq_if.c_o;
        for (int k = 0; k < 10; k++) begin
            check("bp_c_stb", sq_if.c_o_stb, 1'b1);
            check("bp_c_stable", sq_if.c_o, cref);
            check("bp_ab_ack", sq_if.ab_i_ack, 1'b0);
            check("bp_busy", busy, 1'b1);
            @(posedge clk);
            #1;
        end
        m = 0;
        while (sq_if.c_o_stb && m < 20) begin
            @(posedge clk);
            #1;
            m++;
        end
        check("bp_idle_after_ack", m, 1);
        check("bp_ab_ack_idle", sq_if.ab_i_ack, 1'b1);
        check("bp_busy_idle", busy, 1'b0);
        v  = f2r(last_c[MW-1 -: W]);
        dv = (v > 160.866604) ? (v - 160.866604) : (160.866604 - v);
        check("c00_within_tol", (dv / 160.866604) < 1.0e-4, 1'b1);
        wait_done("datapath_done");

        // Reset while waiting on element (1,3): partial C discarded, no further issue.
        a = rndm();
        b = rndm();
        base = n_issue;
        load(a, b, model_c(a, b));
        g = 0;
        while (!(sq_if.result_i_ack && (n_issue - base) == 8) && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("reach_wait_1_3", g < 100, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_row_q.delete();
        exp_col_q.delete();
        exp_c_q.delete();
        have_row = 0;
        have_col = 0;
        check("mid_rst_ab_ack", sq_if.ab_i_ack, 1'b0);
        check("mid_rst_row_stb", sq_if.row_o_stb, 1'b0);
        check("mid_rst_col_stb", sq_if.column_o_stb, 1'b0);
        check("mid_rst_res_ack", sq_if.result_i_ack, 1'b0);
        check("mid_rst_c_stb", sq_if.c_o_stb, 1'b0);
        check("mid_rst_c_o", sq_if.c_o, '0);
        check("mid_rst_busy", busy, 1'b0);
        base = n_issue;
        @(posedge clk);
        #1;
        check("post_rst_ab_ack", sq_if.ab_i_ack, 1'b1);
        check("post_rst_res_ack", sq_if.result_i_ack, 1'b0);
        check("post_rst_row_stb", sq_if.row_o_stb, 1'b0);
        check("post_rst_c_o", sq_if.c_o, '0);
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_no_issue", n_issue - base, 0);

        // Fresh load after the abort must produce a complete, correct C.
        a = rndm();
        b = rndm();
        base = n_issue;
        load(a, b, model_c(a, b));
        wait_done("fresh_done");
        check("fresh_issue_count", n_issue - base, 16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
